// File: rtl/i2s_receiver.sv
// Philips-format I2S receiver: oversamples the async bus on the system clock,
// de-serialises left/right words and publishes {left,right} through a valid/ready register.
module i2s_receiver #(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               sclk_in,
    input  logic               lrclk_in,
    input  logic               sd_in,
    output logic [2*WIDTH-1:0] rx_data,
    output logic               rx_valid,
    input  logic               rx_ready,
    output logic               locked,
    output logic               frame_error,
    output logic               overrun
);

    localparam int CW = $clog2(WIDTH + 2);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_MAX  = CW'(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, LEFT, RIGHT} state_t;

    state_t                 state, state_next;
    logic [SYNC_STAGES-1:0] sclk_sync, lrclk_sync, sd_sync;
    logic                   sclk_prev, ws_prev;
    logic [CW-1:0]          bit_cnt;
    logic [WIDTH-1:0]       shreg, left_word, closed_word;
    logic                   rise, ws, sbit, word_close, word_ok;
    logic                   err, store_left, frame_done;

    always_ff @(posedge clock) begin
        if (reset) begin
            sclk_sync  <= '0;
            lrclk_sync <= '0;
            sd_sync    <= '0;
            sclk_prev  <= 1'b0;
        end else begin
            sclk_sync  <= {sclk_sync[SYNC_STAGES-2:0], sclk_in};
            lrclk_sync <= {lrclk_sync[SYNC_STAGES-2:0], lrclk_in};
            sd_sync    <= {sd_sync[SYNC_STAGES-2:0], sd_in};
            sclk_prev  <= sclk_sync[SYNC_STAGES-1];
        end
    end

    // A change of word select on a rise marks that rise's bit as the LSB of the closing word.
    assign rise        = sclk_sync[SYNC_STAGES-1] & ~sclk_prev;
    assign ws          = lrclk_sync[SYNC_STAGES-1];
    assign sbit        = sd_sync[SYNC_STAGES-1];
    assign word_close  = rise & (ws != ws_prev);
    assign closed_word = {shreg[WIDTH-2:0], sbit};
    assign word_ok     = (bit_cnt == CNT_LAST);
    assign locked      = (state != IDLE);

    always_comb begin
        state_next = state;
        err        = 1'b0;
        store_left = 1'b0;
        frame_done = 1'b0;
        if (word_close) begin
            case (state)
                IDLE: begin
                    if (!ws) state_next = LEFT;
                end
                LEFT: begin
                    if (!word_ok) begin
                        err        = 1'b1;
                        state_next = IDLE;
                    end else begin
                        store_left = 1'b1;
                        state_next = RIGHT;
                    end
                end
                RIGHT: begin
                    if (!word_ok) begin
                        err        = 1'b1;
                        state_next = IDLE;
                    end else begin
                        frame_done = 1'b1;
                        state_next = LEFT;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            ws_prev     <= 1'b0;
            bit_cnt     <= '0;
            shreg       <= '0;
            left_word   <= '0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            frame_error <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            state       <= state_next;
            frame_error <= err;
            overrun     <= 1'b0;
            if (rise) begin
                ws_prev <= ws;
                if (word_close) begin
                    bit_cnt <= '0;
                end else begin
                    if (bit_cnt < CNT_FULL) shreg <= closed_word;
                    if (bit_cnt != CNT_MAX) bit_cnt <= bit_cnt + 1'b1;
                end
            end
            if (store_left) left_word <= closed_word;
            // A completed frame only replaces the output if the old one is gone or leaving now.
            if (frame_done) begin
                if (!rx_valid || rx_ready) begin
                    rx_data  <= {left_word, closed_word};
                    rx_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_i2s_receiver.sv
// Bench for i2s_receiver: drives a Philips I2S bit stream built from a word list and
// compares received frames against a word-level reference model.
module tb_i2s_receiver;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       sclk_in = 1'b0, lrclk_in = 1'b0, sd_in = 1'b0;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid, locked, frame_error, overrun;

    int total = 0;
    int bad   = 0;

    i2s_receiver #(.WIDTH(4), .SYNC_STAGES(2)) dut (
        .clock(clk), .reset(reset), .sclk_in(sclk_in), .lrclk_in(lrclk_in), .sd_in(sd_in),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .locked(locked), .frame_error(frame_error), .overrun(overrun)
    );

    always #5 clk = ~clk;

    // word list awaiting transmission, and the reference model state
    bit         w_ch[$];
    int         w_len[$];
    logic [7:0] w_val[$];
    bit         next_ch;
    int         m_state;   // 0 unlocked, 1 expecting left, 2 expecting right
    logic [3:0] m_left;
    logic [7:0] exp_q[$];
    int         exp_err;

    // observations
    logic [7:0] got[$];
    int         n_ovr, n_err, n_drop, n_vld;
    bit         hold, prev_lock;
    logic [7:0] held;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Word-level rules: a closing right word locks; while locked a wrong-length word
    // drops back to unlocked; a good right word after a good left word yields a frame.
    task automatic add_word(input int len, input logic [7:0] val);
        w_ch.push_back(next_ch);
        w_len.push_back(len);
        w_val.push_back(val);
        case (m_state)
            0: if (next_ch) m_state = 1;
            1: if (len != 4) begin exp_err++; m_state = 0; end
               else begin m_left = val[3:0]; m_state = 2; end
            default: if (len != 4) begin exp_err++; m_state = 0; end
               else begin exp_q.push_back({m_left, val[3:0]}); m_state = 1; end
        endcase
        next_ch = ~next_ch;
    endtask

    task automatic slot(input logic ws, input logic b, input bit pulse);
        sclk_in  = 1'b0;
        lrclk_in = ws;
        sd_in    = b;
        repeat (4) tick();
        sclk_in = 1'b1;
        if (pulse) begin
            tick();
            tick();
            rx_ready = 1'b1;
            tick();
            rx_ready = 1'b0;
            chk("t6_ovr", overrun, 0);
            chk("t6_vld", rx_valid, 1);
            chk("t6_data", rx_data, exp_q[exp_q.size()-1]);
            tick();
        end else begin
            repeat (4) tick();
        end
    endtask

    // Word select leads data by one slot: each slot carries the channel of the next bit.
    task automatic flush(input bit pulse);
        logic bq[$];
        logic cq[$];
        for (int i = 0; i < w_len.size(); i++)
            for (int j = w_len[i] - 1; j >= 0; j--) begin
                bq.push_back(w_val[i][j]);
                cq.push_back(w_ch[i]);
            end
        cq.push_back(next_ch);
        for (int k = 0; k < bq.size(); k++)
            slot(cq[k+1], bq[k], pulse && (k == bq.size() - 1));
        w_ch.delete();
        w_len.delete();
        w_val.delete();
        repeat (4) tick();
    endtask

    task automatic start_phase();
        got.delete();
        exp_q.delete();
        exp_err = 0;
        n_ovr = 0; n_err = 0; n_drop = 0; n_vld = 0;
    endtask

    task automatic cmp_frames(input string tag);
        chk({tag, "_count"}, got.size(), exp_q.size());
        for (int i = 0; i < got.size() && i < exp_q.size(); i++)
            chk({tag, "_frame"}, got[i], exp_q[i]);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        sclk_in = 1'b0; lrclk_in = 1'b0; sd_in = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        m_state = 0;
        next_ch = 1'b1;
        chk("rst_valid", rx_valid, 0);
        chk("rst_data", rx_data, 0);
        chk("rst_locked", locked, 0);
        chk("rst_ferr", frame_error, 0);
        chk("rst_ovr", overrun, 0);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                hold = 1'b0;
                prev_lock = 1'b0;
            end else begin
                if (rx_valid && rx_ready) got.push_back(rx_data);
                if (overrun) n_ovr++;
                if (frame_error) n_err++;
                if (rx_valid) n_vld++;
                if (prev_lock && !locked) n_drop++;
                if (hold && rx_valid) chk("hold_stable", rx_data, held);
                hold = rx_valid && !rx_ready;
                held = rx_data;
                prev_lock = locked;
            end
        end
    end

    initial begin
        m_state = 0; next_ch = 1'b1; m_left = '0;
        start_phase();
        do_reset();

        // T1: single frame A5 with the consumer always ready
        start_phase();
        rx_ready = 1'b1;
        add_word(4, 8'h0); add_word(4, 8'hA); add_word(4, 8'h5);
        flush(0);
        cmp_frames("t1");
        chk("t1_vld_cycles", n_vld, exp_q.size());
        chk("t1_ovr", n_ovr, 0);

        // T2: three frames with the consumer stalled
        start_phase();
        rx_ready = 1'b0;
        add_word(4, 8'hA); add_word(4, 8'h5); add_word(4, 8'h3);
        add_word(4, 8'hC); add_word(4, 8'hF); add_word(4, 8'h0);
        flush(0);
        chk("t2_valid", rx_valid, 1);
        chk("t2_data", rx_data, exp_q[0]);
        chk("t2_ovr", n_ovr, exp_q.size() - 1);
        rx_ready = 1'b1;
        tick(); tick();
        chk("t2_drain_n", got.size(), 1);
        if (got.size() > 0) chk("t2_drain", got[0], exp_q[0]);

        // T3: short left word, then recovery
        start_phase();
        add_word(3, 8'h5); add_word(4, 8'h6); add_word(4, 8'h9); add_word(4, 8'h2);
        flush(0);
        cmp_frames("t3");
        chk("t3_ferr", n_err, exp_err);
        chk("t3_drop", n_drop, 1);
        chk("t3_locked", locked, 1);

        // random frames with occasional wrong-length words
        start_phase();
        for (int i = 0; i < 48; i++) begin
            int len;
            len = 4;
            if ($urandom_range(0, 99) < 15) begin
                case ($urandom_range(0, 3))
                    0: len = 2;
                    1: len = 3;
                    2: len = 5;
                    default: len = 6;
                endcase
            end
            add_word(len, 8'($urandom_range(0, (1 << len) - 1)));
        end
        flush(0);
        cmp_frames("rnd");
        chk("rnd_ferr", n_err, exp_err);
        chk("rnd_ovr", n_ovr, 0);

        // T4: stream begins mid-right-word after reset
        do_reset();
        start_phase();
        add_word(2, 8'h2); add_word(4, 8'hC); add_word(4, 8'h3);
        flush(0);
        cmp_frames("t4");
        chk("t4_ferr", n_err, 0);
        chk("t4_vld_cycles", n_vld, 1);

        // T5: reset in the middle of the left word of 7E
        start_phase();
        add_word(4, 8'h7); add_word(4, 8'hE); add_word(4, 8'h8); add_word(4, 8'h1);
        fork
            flush(0);
            begin
                repeat (12) tick();
                chk("t5_locked_before", locked, 1);
                reset = 1'b1;
                tick(); tick();
                chk("t5_rst_valid", rx_valid, 0);
                chk("t5_rst_data", rx_data, 0);
                chk("t5_rst_locked", locked, 0);
                chk("t5_rst_flags", {frame_error, overrun}, 0);
                reset = 1'b0;
            end
        join
        chk("t5_count", got.size(), 1);
        if (got.size() > 0) chk("t5_frame", got[0], 8'h81);
        chk("t5_ferr", n_err, 0);

        // T6: accept coincides with the next frame completing
        start_phase();
        rx_ready = 1'b0;
        add_word(4, 8'h5); add_word(4, 8'hA);
        flush(0);
        chk("t6_pending", rx_valid, 1);
        add_word(4, 8'h6); add_word(4, 8'h9);
        flush(1);
        rx_ready = 1'b1;
        tick(); tick();
        cmp_frames("t6");
        chk("t6_ovr_total", n_ovr, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
